// File: rtl/sa_pkg.sv
// Shared types and widths for the systolic-array BRAM loader.
// Optional build macro: SA_BRAM_TRANSPOSE_EN (column-major weight remap).
package sa_pkg;

   localparam int unsigned ADDR_W    = 17;
   localparam int unsigned OFS_W     = 15;
   localparam int unsigned DATA_W    = 8;
   localparam int unsigned REG_W     = 2;
   localparam int unsigned WGT_DEPTH = 1024;
   localparam int unsigned WGT_OFS_W = $clog2(WGT_DEPTH);

   typedef enum logic [REG_W-1:0] {
      REG_DATA = 2'b00,
      REG_WGT  = 2'b01
   } region_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/sa_bram_loader_if.sv
// Command, byte-stream and BRAM write-port bundle for the loader.
// Optional build macro: SA_BRAM_TRANSPOSE_EN (affects the loader, not this bundle).
interface sa_bram_loader_if;
   import sa_pkg::*;

   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [REG_W-1:0]     cmd_region;
   logic [OFS_W-1:0]     cmd_base;
   logic [OFS_W-1:0]     cmd_len;
   logic                 s_valid;
   logic                 s_ready;
   logic [DATA_W-1:0]    s_data;
   logic                 s_last;
   logic                 wea;
   logic [ADDR_W-1:0]    addra;
   logic [DATA_W-1:0]    dia;
   logic                 done_o;
   logic                 err_o;

   // Host / DMA side: issues commands and bytes, observes the write port.
   modport master (
      output cmd_valid, cmd_region, cmd_base, cmd_len,
      output s_valid, s_data, s_last,
      input  cmd_ready, s_ready, wea, addra, dia, done_o, err_o
   );

   // Loader side: accepts commands and bytes, drives the write port.
   modport slave (
      input  cmd_valid, cmd_region, cmd_base, cmd_len,
      input  s_valid, s_data, s_last,
      output cmd_ready, s_ready, wea, addra, dia, done_o, err_o
   );

endinterface

// File: rtl/sa_addr_gen.sv
// Combinational region offset generator: wrap per region and optional
// column-major weight remap.
// Optional build macro: SA_BRAM_TRANSPOSE_EN.
module sa_addr_gen
   import sa_pkg::*;
(
   input  logic [REG_W-1:0] region_i,
   input  logic [OFS_W-1:0] base_i,
   input  logic [OFS_W-1:0] count_i,
   output logic [OFS_W-1:0] ofs_o
);

   logic [WGT_OFS_W-1:0] wgt_idx_c;
   logic [WGT_OFS_W-1:0] wgt_ofs_c;

   // Data offsets wrap at the 15-bit field; weight offsets wrap at WGT_DEPTH.
   always_comb begin
      wgt_idx_c = '0;
      wgt_ofs_c = '0;
      ofs_o     = '0;
`ifdef SA_BRAM_TRANSPOSE_EN
      wgt_idx_c = {count_i[3:0], count_i[9:4]};
`else
      wgt_idx_c = count_i[WGT_OFS_W-1:0];
`endif
      wgt_ofs_c = base_i[WGT_OFS_W-1:0] + wgt_idx_c;
      if (region_i == REG_WGT) begin
         ofs_o = OFS_W'(wgt_ofs_c);
      end else begin
         ofs_o = base_i + count_i;
      end
   end

endmodule

// File: rtl/sa_bram_loader.sv
// Write-side master for the systolic-array BRAM load port: turns a load
// command plus a valid/ready byte stream into one BRAM write per byte.
// Optional build macro: SA_BRAM_TRANSPOSE_EN (column-major weight remap).
module sa_bram_loader
   import sa_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   sa_bram_loader_if.slave  bus
);

   state_e               state_q;
   logic [REG_W-1:0]     region_q;
   logic [OFS_W-1:0]     base_q;
   logic [OFS_W-1:0]     len_q;
   logic [OFS_W-1:0]     count_q;
   logic [OFS_W-1:0]     count_d;
   logic [OFS_W-1:0]     ofs_c;
   logic                 cmd_ready_q;
   logic                 s_ready_q;
   logic                 wea_q;
   logic [ADDR_W-1:0]    addra_q;
   logic [DATA_W-1:0]    dia_q;
   logic                 done_q;
   logic                 err_q;
   logic                 cmd_fire_c;
   logic                 byte_fire_c;
   logic                 last_cnt_c;

   assign cmd_fire_c  = bus.cmd_valid && cmd_ready_q;
   assign byte_fire_c = bus.s_valid && s_ready_q;
   assign last_cnt_c  = (count_q == (len_q - OFS_W'(1)));
   assign count_d     = count_q + OFS_W'(1);

   sa_addr_gen u_addr_gen (
      .region_i (region_q),
      .base_i   (base_q),
      .count_i  (count_q),
      .ofs_o    (ofs_c)
   );

   // Load FSM with registered handshake, write-port and status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         region_q    <= '0;
         base_q      <= '0;
         len_q       <= '0;
         count_q     <= '0;
         cmd_ready_q <= 1'b1;
         s_ready_q   <= 1'b0;
         wea_q       <= 1'b0;
         addra_q     <= '0;
         dia_q       <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         wea_q  <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cmd_fire_c) begin
                  region_q    <= bus.cmd_region;
                  base_q      <= bus.cmd_base;
                  len_q       <= bus.cmd_len;
                  count_q     <= '0;
                  cmd_ready_q <= 1'b0;
                  if (bus.cmd_region[1]) begin
                     err_q   <= 1'b1;
                     state_q <= DONE;
                  end else if (bus.cmd_len == '0) begin
                     err_q   <= 1'b0;
                     state_q <= DONE;
                  end else begin
                     err_q     <= 1'b0;
                     s_ready_q <= 1'b1;
                     state_q   <= LOAD;
                  end
               end
            end
            LOAD: begin
               if (byte_fire_c) begin
                  wea_q   <= 1'b1;
                  addra_q <= {region_q, ofs_c};
                  dia_q   <= bus.s_data;
                  count_q <= count_d;
                  // Ends on the len-th byte or an early s_last; disagreement is an error.
                  if (last_cnt_c || bus.s_last) begin
                     s_ready_q <= 1'b0;
                     state_q   <= DONE;
                     if (last_cnt_c != bus.s_last) begin
                        err_q <= 1'b1;
                     end
                  end
               end
            end
            DONE: begin
               done_q      <= 1'b1;
               cmd_ready_q <= 1'b1;
               state_q     <= IDLE;
            end
            default: begin
               cmd_ready_q <= 1'b1;
               s_ready_q   <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign bus.cmd_ready = cmd_ready_q;
   assign bus.s_ready   = s_ready_q;
   assign bus.wea       = wea_q;
   assign bus.addra     = addra_q;
   assign bus.dia       = dia_q;
   assign bus.done_o    = done_q;
   assign bus.err_o     = err_q;

endmodule

// File: tb/tb_sa_bram_loader.sv
// Directed self-checking bench for sa_bram_loader.
// Optional build macro: SA_BRAM_TRANSPOSE_EN (enables the remap scenario).
module tb_sa_bram_loader;
   import sa_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   logic [ADDR_W-1:0] wr_addr [$];
   logic [DATA_W-1:0] wr_data [$];
   int                wr_cyc  [$];
   int                done_cnt;
   int                done_cyc;
   logic              err_at_done;

   sa_bram_loader_if bus ();

   sa_bram_loader dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Write-port log sampled mid-cycle.
   always @(negedge clk) begin
      if (bus.wea) begin
         wr_addr.push_back(bus.addra);
         wr_data.push_back(bus.dia);
         wr_cyc.push_back(cyc);
      end
      if (bus.done_o) begin
         done_cnt    = done_cnt + 1;
         done_cyc    = cyc;
         err_at_done = bus.err_o;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
      wr_cyc.delete();
      done_cnt    = 0;
      done_cyc    = -1;
      err_at_done = 1'b0;
   endtask

   task automatic send_cmd(input logic [1:0] region, input logic [OFS_W-1:0] base,
                           input logic [OFS_W-1:0] len);
      int n = 0;
      bus.cmd_valid  = 1'b1;
      bus.cmd_region = region;
      bus.cmd_base   = base;
      bus.cmd_len    = len;
      while (!bus.cmd_ready && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 20) begin
         failures++;
         $display("FAIL cmd_accept_timeout got=cmd_ready_low exp=cmd_ready_high");
      end
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   // Leaves s_valid high so consecutive calls stream back-to-back.
   task automatic send_byte(input logic [DATA_W-1:0] data, input logic last);
      int n = 0;
      bus.s_valid = 1'b1;
      bus.s_data  = data;
      bus.s_last  = last;
      while (!bus.s_ready && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 20) begin
         failures++;
         $display("FAIL byte_accept_timeout got=s_ready_low exp=s_ready_high");
      end
      tick();
   endtask

   task automatic stream_end();
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      repeat (4) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      checks++; if (bus.wea !== 1'b0) begin failures++; $display("FAIL rst_wea got=%b exp=0", bus.wea); end
      checks++; if (bus.addra !== 17'h0) begin failures++; $display("FAIL rst_addra got=%h exp=0", bus.addra); end
      checks++; if (bus.dia !== 8'h0) begin failures++; $display("FAIL rst_dia got=%h exp=0", bus.dia); end
      checks++; if (bus.done_o !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", bus.done_o); end
      checks++; if (bus.err_o !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", bus.err_o); end
      checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_cmd_ready got=%b exp=1", bus.cmd_ready); end
      checks++; if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL rst_s_ready got=%b exp=0", bus.s_ready); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_data_load();
      logic [ADDR_W-1:0] ea;
      logic [DATA_W-1:0] ed;
      clear_log();
      send_cmd(2'b00, 15'h0010, 15'd4);
      for (int i = 0; i < 4; i++) send_byte(DATA_W'(8'hA0 + i), (i == 3));
      stream_end();
      checks++; if (wr_addr.size() !== 4) begin failures++; $display("FAIL data_nwr got=%0d exp=4", wr_addr.size()); end
      for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
         ea = ADDR_W'(32'h10 + i);
         ed = DATA_W'(8'hA0 + i);
         checks++; if (wr_addr[i] !== ea) begin failures++; $display("FAIL data_addr[%0d] got=%h exp=%h", i, wr_addr[i], ea); end
         checks++; if (wr_data[i] !== ed) begin failures++; $display("FAIL data_dia[%0d] got=%h exp=%h", i, wr_data[i], ed); end
         if (i > 0) begin
            checks++; if (wr_cyc[i] !== wr_cyc[i-1] + 1) begin failures++; $display("FAIL data_b2b[%0d] got=%0d exp=%0d", i, wr_cyc[i], wr_cyc[i-1] + 1); end
         end
      end
      checks++; if (done_cnt !== 1) begin failures++; $display("FAIL data_done_cnt got=%0d exp=1", done_cnt); end
      if (wr_cyc.size() == 4) begin
         checks++; if (done_cyc !== wr_cyc[3] + 1) begin failures++; $display("FAIL data_done_timing got=%0d exp=%0d", done_cyc, wr_cyc[3] + 1); end
      end
      checks++; if (err_at_done !== 1'b0) begin failures++; $display("FAIL data_err got=%b exp=0", err_at_done); end
   endtask

   task automatic test_wgt_wrap();
      logic [ADDR_W-1:0] exp_a [4];
`ifdef SA_BRAM_TRANSPOSE_EN
      exp_a[0] = 17'h083FE; exp_a[1] = 17'h0803E; exp_a[2] = 17'h0807E; exp_a[3] = 17'h080BE;
`else
      exp_a[0] = 17'h083FE; exp_a[1] = 17'h083FF; exp_a[2] = 17'h08000; exp_a[3] = 17'h08001;
`endif
      clear_log();
      send_cmd(2'b01, 15'h03FE, 15'd4);
      for (int i = 0; i < 4; i++) send_byte(DATA_W'(8'h50 + i), (i == 3));
      stream_end();
      checks++; if (wr_addr.size() !== 4) begin failures++; $display("FAIL wgt_nwr got=%0d exp=4", wr_addr.size()); end
      for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
         checks++; if (wr_addr[i] !== exp_a[i]) begin failures++; $display("FAIL wgt_addr[%0d] got=%h exp=%h", i, wr_addr[i], exp_a[i]); end
      end
      checks++; if (err_at_done !== 1'b0) begin failures++; $display("FAIL wgt_err got=%b exp=0", err_at_done); end
   endtask

   task automatic test_last_mismatch();
      // Early s_last on byte 2 of 3.
      clear_log();
      send_cmd(2'b00, 15'h0100, 15'd3);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b1);
      stream_end();
      checks++; if (wr_addr.size() !== 2) begin failures++; $display("FAIL early_nwr got=%0d exp=2", wr_addr.size()); end
      if (wr_addr.size() == 2) begin
         checks++; if (wr_addr[1] !== 17'h00101) begin failures++; $display("FAIL early_addr got=%h exp=00101", wr_addr[1]); end
         checks++; if (wr_data[1] !== 8'h22) begin failures++; $display("FAIL early_dia got=%h exp=22", wr_data[1]); end
      end
      checks++; if (done_cnt !== 1) begin failures++; $display("FAIL early_done_cnt got=%0d exp=1", done_cnt); end
      checks++; if (bus.err_o !== 1'b1) begin failures++; $display("FAIL early_err got=%b exp=1", bus.err_o); end
      // Next accepted command clears the sticky error.
      clear_log();
      send_cmd(2'b00, 15'h0000, 15'd2);
      checks++; if (bus.err_o !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", bus.err_o); end
      // Missing s_last on the final byte: written, but flagged.
      send_byte(8'h33, 1'b0);
      send_byte(8'h44, 1'b0);
      stream_end();
      checks++; if (wr_addr.size() !== 2) begin failures++; $display("FAIL nolast_nwr got=%0d exp=2", wr_addr.size()); end
      checks++; if (err_at_done !== 1'b1) begin failures++; $display("FAIL nolast_err got=%b exp=1", err_at_done); end
   endtask

   task automatic test_illegal_and_zero();
      clear_log();
      send_cmd(2'b10, 15'h0000, 15'd5);
      bus.s_valid = 1'b1; bus.s_data = 8'hEE; bus.s_last = 1'b1;
      stream_end();
      checks++; if (wr_addr.size() !== 0) begin failures++; $display("FAIL illegal_nwr got=%0d exp=0", wr_addr.size()); end
      checks++; if (done_cnt !== 1) begin failures++; $display("FAIL illegal_done_cnt got=%0d exp=1", done_cnt); end
      checks++; if (err_at_done !== 1'b1) begin failures++; $display("FAIL illegal_err got=%b exp=1", err_at_done); end
      clear_log();
      send_cmd(2'b00, 15'h0000, 15'd0);
      stream_end();
      checks++; if (wr_addr.size() !== 0) begin failures++; $display("FAIL len0_nwr got=%0d exp=0", wr_addr.size()); end
      checks++; if (done_cnt !== 1) begin failures++; $display("FAIL len0_done_cnt got=%0d exp=1", done_cnt); end
      checks++; if (err_at_done !== 1'b0) begin failures++; $display("FAIL len0_err got=%b exp=0", err_at_done); end
   endtask

   task automatic test_gaps();
      clear_log();
      send_cmd(2'b00, 15'h0040, 15'd3);
      send_byte(8'hB0, 1'b0);
      bus.s_valid = 1'b0;
      bus.s_data  = 8'hFF;
      bus.s_last  = 1'b1;
      tick();
      send_byte(8'hB1, 1'b0);
      send_byte(8'hB2, 1'b1);
      stream_end();
      checks++; if (wr_addr.size() !== 3) begin failures++; $display("FAIL gap_nwr got=%0d exp=3", wr_addr.size()); end
      for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
         checks++; if (wr_addr[i] !== ADDR_W'(32'h40 + i)) begin failures++; $display("FAIL gap_addr[%0d] got=%h exp=%h", i, wr_addr[i], ADDR_W'(32'h40 + i)); end
         checks++; if (wr_data[i] !== DATA_W'(8'hB0 + i)) begin failures++; $display("FAIL gap_dia[%0d] got=%h exp=%h", i, wr_data[i], DATA_W'(8'hB0 + i)); end
      end
      if (wr_cyc.size() == 3) begin
         checks++; if (wr_cyc[1] !== wr_cyc[0] + 2) begin failures++; $display("FAIL gap_bubble got=%0d exp=%0d", wr_cyc[1], wr_cyc[0] + 2); end
         checks++; if (wr_cyc[2] !== wr_cyc[1] + 1) begin failures++; $display("FAIL gap_b2b got=%0d exp=%0d", wr_cyc[2], wr_cyc[1] + 1); end
      end
      checks++; if (err_at_done !== 1'b0) begin failures++; $display("FAIL gap_err got=%b exp=0", err_at_done); end
   endtask

   task automatic test_reset_mid_load();
      clear_log();
      send_cmd(2'b00, 15'h0050, 15'd4);
      send_byte(8'hC0, 1'b0);
      send_byte(8'hC1, 1'b0);
      rst         = 1'b1;
      bus.s_valid = 1'b0;
      tick();
      checks++; if (bus.wea !== 1'b0) begin failures++; $display("FAIL midrst_wea got=%b exp=0", bus.wea); end
      checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL midrst_cmd_ready got=%b exp=1", bus.cmd_ready); end
      checks++; if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL midrst_s_ready got=%b exp=0", bus.s_ready); end
      rst = 1'b0;
      repeat (4) tick();
      checks++; if (wr_addr.size() !== 2) begin failures++; $display("FAIL midrst_nwr got=%0d exp=2", wr_addr.size()); end
      checks++; if (done_cnt !== 0) begin failures++; $display("FAIL midrst_done got=%0d exp=0", done_cnt); end
   endtask

`ifdef SA_BRAM_TRANSPOSE_EN
   task automatic test_transpose();
      logic [ADDR_W-1:0] ea;
      clear_log();
      send_cmd(2'b01, 15'h0000, 15'd17);
      for (int k = 0; k < 17; k++) send_byte(DATA_W'(k), (k == 16));
      stream_end();
      checks++; if (wr_addr.size() !== 17) begin failures++; $display("FAIL tr_nwr got=%0d exp=17", wr_addr.size()); end
      for (int k = 0; k < 17 && k < wr_addr.size(); k++) begin
         ea = (k < 16) ? ADDR_W'(32'h08000 + k * 64) : 17'h08001;
         checks++; if (wr_addr[k] !== ea) begin failures++; $display("FAIL tr_addr[%0d] got=%h exp=%h", k, wr_addr[k], ea); end
      end
   endtask
`endif

   initial begin
      rst            = 1'b1;
      bus.cmd_valid  = 1'b0;
      bus.cmd_region = 2'b00;
      bus.cmd_base   = '0;
      bus.cmd_len    = '0;
      bus.s_valid    = 1'b0;
      bus.s_data     = '0;
      bus.s_last     = 1'b0;
      clear_log();
      test_reset();
      test_data_load();
      test_wgt_wrap();
      test_last_mismatch();
      test_illegal_and_zero();
      test_gaps();
      test_reset_mid_load();
`ifdef SA_BRAM_TRANSPOSE_EN
      test_transpose();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
